// File: rtl/aes_pkg.sv
// Shared AES helpers: Rcon table, GF(2^8) arithmetic, S-box, RotWord, FSM states.
// Optional feature macro: AES_INV_KEY_DERIVE_EN (adds the DERIVE state).
package aes_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned KEY_W    = 128;
    localparam int unsigned ROUND_W  = 4;
    localparam int unsigned RCON_NUM = 10;

    localparam logic [7:0] RCON [RCON_NUM] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef AES_INV_KEY_DERIVE_EN
        ST_DERIVE = 2'd1,
`endif
        ST_EMIT   = 2'd2
    } state_e;

    // Rcon word with the constant in byte 3; out-of-range index yields zero.
    function automatic logic [WORD_W-1:0] rcon_word(input logic [ROUND_W-1:0] idx);
        logic [WORD_W-1:0] w;
        w = '0;
        if (idx < ROUND_W'(RCON_NUM)) begin
            w = {RCON[idx], 24'h000000};
        end
        return w;
    endfunction

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // S-box affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] sbox_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return sbox_affine(gf_inv(b));
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: AES S-box applied to each of the four bytes of a word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Four independent byte substitutions.
    always_comb begin
        word_out = '0;
        for (int i = 0; i < 4; i++) begin
            word_out[i*8 +: 8] = sbox(word_in[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule: streams round keys 10..0 from the round-10 key.
// Optional feature macro: AES_INV_KEY_DERIVE_EN (key_in is the cipher key and the
// round-10 key is first derived by ten forward expansion steps).
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         done
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   w_q, w_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0]  w0, w1, w2, w3;
    logic [WORD_W-1:0]  b0, b1, b2, b3;
    logic [WORD_W-1:0]  sub_in_c, sub_out_c;
    logic [ROUND_W-1:0] rcon_idx_c;
    logic [KEY_W-1:0]   bwd_w_c;

    assign {w0, w1, w2, w3} = w_q;

    // Backward step words; w0 needs SubWord of the new w3.
    always_comb begin
        b3 = w3 ^ w2;
        b2 = w2 ^ w1;
        b1 = w1 ^ w0;
        b0 = w0 ^ sub_out_c ^ rcon_word(rcon_idx_c);
        bwd_w_c = {b0, b1, b2, b3};
    end

`ifdef AES_INV_KEY_DERIVE_EN
    logic [WORD_W-1:0] f0, f1, f2, f3;
    logic [KEY_W-1:0]  fwd_w_c;

    // Single SubWord shared between forward (DERIVE) and backward (EMIT) steps.
    always_comb begin
        if (state_q == ST_DERIVE) begin
            sub_in_c   = rot_word(w3);
            rcon_idx_c = round_q;
        end else begin
            sub_in_c   = rot_word(b3);
            rcon_idx_c = round_q - ROUND_W'(1);
        end
    end

    // Forward expansion step using Rcon[round_q].
    always_comb begin
        f0 = w0 ^ sub_out_c ^ rcon_word(rcon_idx_c);
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        fwd_w_c = {f0, f1, f2, f3};
    end
`else
    // Backward step only: SubWord input is RotWord of the recovered w3.
    always_comb begin
        sub_in_c   = rot_word(b3);
        rcon_idx_c = round_q - ROUND_W'(1);
    end
`endif

    aes_sub_word u_sub_word (
        .word_in  (sub_in_c),
        .word_out (sub_out_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        round_d = round_q;
        ready_d = ready_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d     = key_in;
                    ready_d = 1'b0;
`ifdef AES_INV_KEY_DERIVE_EN
                    round_d = '0;
                    state_d = ST_DERIVE;
`else
                    round_d = LAST_ROUND;
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
`endif
                end
            end
`ifdef AES_INV_KEY_DERIVE_EN
            ST_DERIVE: begin
                w_d     = fwd_w_c;
                round_d = round_q + ROUND_W'(1);
                if (round_q == LAST_ROUND - ROUND_W'(1)) begin
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end
            end
`endif
            ST_EMIT: begin
                if (rk_ready) begin
                    if (round_q == '0) begin
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        w_d     = bwd_w_c;
                        round_d = round_q - ROUND_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            round_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            round_q <= round_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign ready    = ready_q;
    assign rk_valid = valid_q;
    assign rk       = w_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 AES-128 key expansion.
module tb_aes_inv_key_sched;

    logic         CLK;
    logic         RST_N;
    logic         start;
    logic [127:0] key_in;
    logic         ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } vec_t;

    vec_t         tbl [11];
    logic [127:0] start_key;

    aes_inv_key_sched #(.NR(10)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .key_in   (key_in),
        .ready    (ready),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_round (rk_round),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ready"},    128'(ready),    128'd1);
        chk({tag, " rk_valid"}, 128'(rk_valid), 128'd0);
        chk({tag, " rk"},       rk,             128'd0);
        chk({tag, " rk_round"}, 128'(rk_round), 128'd0);
        chk({tag, " done"},     128'(done),     128'd0);
    endtask

    task automatic expect_key(input int idx);
        chk($sformatf("rk_valid[%0d]", idx), 128'(rk_valid), 128'd1);
        chk($sformatf("ready[%0d]", idx),    128'(ready),    128'd0);
        chk($sformatf("rk_round[%0d]", idx), 128'(rk_round), 128'(tbl[idx].round));
        chk($sformatf("rk[%0d]", idx),       rk,             tbl[idx].key);
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic wait_first();
`ifdef AES_INV_KEY_DERIVE_EN
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("derive valid[%0d]", i), 128'(rk_valid), 128'd0);
            chk($sformatf("derive ready[%0d]", i), 128'(ready),    128'd0);
            @(negedge CLK);
        end
`endif
    endtask

    // Walk keys from idx to round 0 with rk_ready=1, then check the done cycle.
    task automatic drain(input int from, input bit poke);
        for (int idx = from; idx <= 10; idx++) begin
            expect_key(idx);
            if (poke) begin
                if (idx >= 2 && idx <= 5) begin
                    start  = 1'b1;
                    key_in = {4{32'hdeadbeef}};
                end else begin
                    start  = 1'b0;
                    key_in = start_key;
                end
            end
            @(negedge CLK);
        end
        chk("done pulse", 128'(done),     128'd1);
        chk("done ready", 128'(ready),    128'd1);
        chk("done valid", 128'(rk_valid), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
`ifdef AES_INV_KEY_DERIVE_EN
        start_key = tbl[10].key;
`else
        start_key = tbl[0].key;
`endif

        RST_N    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b1;
        key_in   = '0;
        @(negedge CLK);
        chk_reset_vals("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        // Plain FIPS-197 sequence.
        start  = 1'b1;
        key_in = start_key;
        @(negedge CLK);
        start = 1'b0;
        wait_first();
        drain(0, 1'b0);
        @(negedge CLK);
        chk("idle done", 128'(done), 128'd0);

        // Backpressure for three cycles while round 9 is shown.
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_first();
        expect_key(0);
        @(negedge CLK);
        expect_key(1);
        rk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            expect_key(1);
        end
        rk_ready = 1'b1;
        @(negedge CLK);
        drain(2, 1'b0);
        @(negedge CLK);

        // start with a different key during EMIT must be ignored.
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_first();
        drain(0, 1'b1);
        @(negedge CLK);
        chk("poke idle ready", 128'(ready), 128'd1);
        chk("poke idle valid", 128'(rk_valid), 128'd0);

        // Reset while round 5 is shown, then restart.
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_first();
        for (int idx = 0; idx < 5; idx++) begin
            expect_key(idx);
            @(negedge CLK);
        end
        expect_key(5);
        RST_N = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge CLK);
        chk_reset_vals("held reset");
        RST_N = 1'b1;
        @(negedge CLK);
        chk_reset_vals("after reset");
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_first();
        drain(0, 1'b0);
        @(negedge CLK);

        // Back-to-back: start held, second sequence begins in the done cycle.
        start = 1'b1;
        @(negedge CLK);
        wait_first();
        drain(0, 1'b0);
        @(negedge CLK);
        start = 1'b0;
        wait_first();
        drain(0, 1'b0);
        @(negedge CLK);
        chk("final done", 128'(done), 128'd0);
        chk("final ready", 128'(ready), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
